// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: instruction width, reset PC,
// NOP encoding and the prefetch queue entry layout.
package instruction_fetch_unit_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO holding fetched words; flush drops everything
// in one edge. The head reads as a NOP entry whenever the queue is empty.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           wr_entry,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !reset)
            mem[wr_ptr] <= wr_entry;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '{instr: NOP, pc_plus4: 32'h0};

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the fetch PC, reads InstructionMemory combinationally
// and buffers words with their PC+4 for decode; redirects flush the queue.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset,
    output logic [31:0]            IMemAddress,
    input  logic [31:0]            IMemData,
    input  logic                   Redirect,
    input  logic [31:0]            RedirectPC,
    input  logic                   DecodeReady,
    output logic                   InstrValid,
    output logic [31:0]            Instruction,
    output logic [31:0]            PCPlus4,
    output logic [31:0]            PCResult,
    output logic [$clog2(DEPTH):0] QueueCount
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc;
    logic [31:0]   pc_next_seq;
    logic [31:0]   redirect_target;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  wr_entry;

    assign pc_next_seq     = pc + 32'd4;
    assign redirect_target = RedirectPC & ~32'h3;

    assign pop  = InstrValid & DecodeReady;
    // A full queue still accepts a word when the head leaves the same edge.
    assign push = ~Redirect & ((count < CW'(DEPTH)) | pop);

    assign wr_entry = '{instr: IMemData, pc_plus4: pc_next_seq};

    always_ff @(posedge Clk) begin
        if (Reset)
            pc <= RESET_PC;
        else if (Redirect)
            pc <= redirect_target;
        else if (push)
            pc <= pc_next_seq;
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk      (Clk),
        .reset    (Reset),
        .flush    (Redirect),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    assign IMemAddress = pc;
    assign PCResult    = pc;
    assign QueueCount  = count;
    assign InstrValid  = (count != '0);
    assign Instruction = head.instr;
    assign PCPlus4     = head.pc_plus4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory returns its own address as data,
// a queue scoreboard tracks expected entries and the fetch PC cycle by cycle.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic        DecodeReady = 1'b0;
    logic [31:0] IMemAddress;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic [31:0] PCResult;
    logic [$clog2(DEPTH):0] QueueCount;

    always #5 Clk = ~Clk;

    assign IMemData = IMemAddress;

    instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .IMemAddress (IMemAddress),
        .IMemData    (IMemData),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .DecodeReady (DecodeReady),
        .InstrValid  (InstrValid),
        .Instruction (Instruction),
        .PCPlus4     (PCPlus4),
        .PCResult    (PCResult),
        .QueueCount  (QueueCount)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb [$];
    logic [31:0] mpc = 32'h0;
    bit          armed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check outputs against the model, apply one cycle of stimulus, advance the model.
    task automatic step(input logic rst, input logic rd, input logic [31:0] tgt, input logic dr);
        logic do_pop, do_push;
        @(negedge Clk);
        if (armed) begin
            chk("valid", 32'(InstrValid), 32'(sb.size() != 0));
            chk("count", 32'(QueueCount), 32'(sb.size()));
            chk("pc", PCResult, mpc);
            chk("imem_addr", IMemAddress, mpc);
            if (sb.size() != 0) begin
                chk("head_instr", Instruction, sb[0][63:32]);
                chk("head_pc4", PCPlus4, sb[0][31:0]);
            end else begin
                chk("empty_instr", Instruction, 32'h0);
                chk("empty_pc4", PCPlus4, 32'h0);
            end
        end
        Reset       = rst;
        Redirect    = rd;
        RedirectPC  = tgt;
        DecodeReady = dr;
        #1;
        if (rst) begin
            sb.delete();
            mpc   = 32'h0;
            armed = 1'b1;
        end else if (rd) begin
            sb.delete();
            mpc = tgt & ~32'h3;
        end else begin
            do_pop  = (sb.size() != 0) && dr;
            do_push = (sb.size() < DEPTH) || do_pop;
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                sb.push_back({mpc, mpc + 32'd4});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge Clk);
    endtask

    task automatic idle(input int n, input logic dr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, dr);
    endtask

    initial begin
        int r;
        // Reset, then stream with decode always ready
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        #2;
        chk("rst_count", 32'(QueueCount), 32'h0);
        chk("rst_valid", 32'(InstrValid), 32'h0);
        chk("rst_pc", PCResult, 32'h0);
        idle(1, 1'b1);
        #2;
        chk("first_instr", Instruction, 32'h0);
        chk("first_pc4", PCPlus4, 32'h4);
        idle(8, 1'b1);

        // Backpressure: fill in DEPTH cycles, fetch stalls at 0x10
        step(1'b1, 1'b0, 32'h0, 1'b0);
        idle(4, 1'b0);
        #2;
        chk("bp_count", 32'(QueueCount), 32'h4);
        chk("bp_pc", PCResult, 32'h10);
        idle(2, 1'b0);
        #2;
        chk("bp_pc_hold", PCResult, 32'h10);
        idle(8, 1'b1);

        // Redirect with three entries held
        step(1'b1, 1'b0, 32'h0, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b1);
        #2;
        chk("rd_count", 32'(QueueCount), 32'h0);
        chk("rd_pc", PCResult, 32'h40);
        idle(1, 1'b1);
        #2;
        chk("rd_instr", Instruction, 32'h40);
        chk("rd_pc4", PCPlus4, 32'h44);
        idle(4, 1'b1);

        // Full queue, pop and redirect together: redirect wins
        idle(6, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        idle(5, 1'b1);

        // Reset with a full queue
        idle(6, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        idle(3, 1'b1);

        // Wraparound and misaligned targets
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        idle(1, 1'b1);
        #2;
        chk("wrap_pc4", PCPlus4, 32'h0);
        chk("wrap_pc", PCResult, 32'h0);
        idle(3, 1'b1);
        step(1'b0, 1'b1, 32'h43, 1'b1);
        #2;
        chk("align_pc", PCResult, 32'h40);
        idle(3, 1'b0);

        // Random decode readiness with occasional redirects and resets
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            step(r < 2, (r >= 2) && (r < 8), $urandom, $urandom_range(0, 3) != 0);
        end
        idle(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
